pipelined_perceptron_predictor: RTL and testbench
=================================================

# pipelined_perceptron_predictor

Parametrised, registered-output perceptron branch direction predictor for the MIPS core fetch stage.
- Keeps a speculative global history register (GHR) that advances on every prediction.
- Restores that history from the feedback snapshot when the branch unit reports a mispredict.
- Trains a weight table from the history snapshot that travels with each branch.
- After reset, clears the weight table with a row-per-cycle sweep instead of a single-cycle table reset.

## Interface
Parameters:
- ADDR_WIDTH, 32: PC width.
- HIST_LEN, 16: history bits per perceptron. Must be ≥ IDX_BITS.
- NUM_PERCEPTRONS, 64: table rows, power of two. IDX_BITS = $clog2(NUM_PERCEPTRONS).
- WEIGHT_BITS, 8: signed weight width.
- THRESHOLD, int'(1.93*HIST_LEN+14): training threshold.
- SUM_BITS (localparam) = WEIGHT_BITS + $clog2(HIST_LEN+1) + 1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- o_ready, out, 1: table initialised. Requests and feedback are ignored while low.
- i_req_valid, in, 1: prediction request.
- i_req_pc, in, ADDR_WIDTH: branch PC.
- o_pred_valid, out, 1: prediction valid, one cycle after the accepted request.
- o_pred_taken, out, 1: 1 = TAKEN.
- o_pred_hist, out, HIST_LEN: speculative GHR used for this prediction. Pipeline carries it to feedback.
- i_fb_valid, in, 1: resolved branch.
- i_fb_pc, in, ADDR_WIDTH: resolved PC.
- i_fb_hist, in, HIST_LEN: o_pred_hist returned by the pipeline.
- i_fb_taken, in, 1: actual outcome.
- i_fb_mispredict, in, 1: predicted direction was wrong.

## Operation
- Index: idx = pc[IDX_BITS+1:2] ^ hist[IDX_BITS-1:0].
  - Requests use the speculative GHR (spec_ghr).
  - Feedback uses i_fb_hist.
- Input encoding: x0 = +1 (bias). For i ≥ 1, xi = +1 if hist[i-1] is 1, else -1.
- Sum: sum = Σ wi·xi, computed in SUM_BITS signed. Prediction is TAKEN iff sum ≥ 0.
- GHR update: {hist[HIST_LEN-2:0], bit}. Bit 0 is the newest.
  - Accepted request: spec_ghr gets the predicted bit.
  - Feedback with i_fb_mispredict: spec_ghr = {i_fb_hist[HIST_LEN-2:0], i_fb_taken}.
- Training on accepted feedback:
  - Recompute fb_sum from the current weights of the feedback row and i_fb_hist.
  - Train if sign(fb_sum ≥ 0) ≠ i_fb_taken, or |fb_sum| ≤ THRESHOLD.
  - Update: wi += (i_fb_taken ? xi : -xi), saturated to [-2^(WEIGHT_BITS-1), 2^(WEIGHT_BITS-1)-1].
  - All weights of the row are written on the same edge.
- FSM states:
  - INIT: a row counter clears one row per cycle, 0 up to NUM_PERCEPTRONS-1, then moves to RUN.
  - RUN: o_ready = 1.
  - rst_n low in any state restarts INIT with the counter at 0.

## Timing
- Reset values: o_ready 0, o_pred_valid 0, o_pred_taken 0, o_pred_hist 0, spec_ghr 0, FSM state INIT.
- o_ready rises exactly NUM_PERCEPTRONS cycles after the first cycle with rst_n high.
- Requests and feedback while o_ready = 0 are dropped: no GHR change, no write, o_pred_valid stays 0.
- Prediction latency is 1 cycle.
  - o_pred_* are registered from the request-cycle spec_ghr and weights.
  - o_pred_valid is high for exactly one cycle per request.
  - Back-to-back requests give back-to-back predictions, each seeing the previous request's speculative bit.
- Same-cycle request and mispredict feedback:
  - The prediction is still produced from the old spec_ghr (the wrong-path consumer discards it).
  - spec_ghr takes the recovery value; the request's shift is discarded.
- Same-cycle request and training of the same row: the prediction reads the pre-update weights. The write lands at the edge.
- Feedback without mispredict never touches spec_ghr.
- No backpressure. At most one request and one feedback per cycle.

## Test plan
- Reset sweep (NUM_PERCEPTRONS=64): o_ready = 0 for 64 cycles after rst_n rises, then 1. Assert rst_n low at cycle 30: o_ready stays 0 and the sweep restarts, taking 64 more cycles after release.
- Zero weights: request pc=0x400 → o_pred_valid one cycle later, o_pred_taken = 1 (sum 0), o_pred_hist = 0.
- Training (HIST_LEN=8, THRESHOLD=29): feedback on pc=0x400, hist=0, taken=0, repeated.
  - fb_sum after each training is -9, -18, -27, -36.
  - The 5th feedback causes no write.
  - A request for that pc/hist then predicts NOT_TAKEN.
- Saturation (WEIGHT_BITS=4, THRESHOLD forced to 200): 10 trainings with taken=1, hist=all-ones → every weight reads 7 and no wrap occurs. The same with taken=0 → every weight reads -8.
- Recovery (HIST_LEN=8): three TAKEN predictions from reset → spec_ghr = 0x07. Mispredict feedback with hist=0x05 and taken=1 → spec_ghr = 0x0B. A same-cycle request returns o_pred_hist = 0x07, and the next request uses 0x0B.
- Same-row collision: a request and a training feedback to the same index in one cycle → the prediction reflects the old weights, and the next request reflects the updated ones.

Source files
------------

// File: rtl/pipelined_perceptron_predictor.sv
// Perceptron branch direction predictor: speculative GHR, one-cycle registered prediction,
// feedback-driven training and a row-per-cycle table clear after reset.
module pipelined_perceptron_predictor #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned HIST_LEN        = 16,
  parameter int unsigned NUM_PERCEPTRONS = 64,
  parameter int unsigned WEIGHT_BITS     = 8,
  parameter int          THRESHOLD       = int'(1.93 * HIST_LEN + 14)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_ready,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  output logic [HIST_LEN-1:0]   o_pred_hist,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic [HIST_LEN-1:0]   i_fb_hist,
  input  logic                  i_fb_taken,
  input  logic                  i_fb_mispredict
);

  localparam int unsigned IDX_BITS = $clog2(NUM_PERCEPTRONS);
  localparam int unsigned SUM_BITS = WEIGHT_BITS + $clog2(HIST_LEN + 1) + 1;

  typedef logic signed [WEIGHT_BITS-1:0] weight_t;
  typedef logic signed [SUM_BITS-1:0]    sum_t;
  typedef enum logic {StInit, StRun} state_e;

  localparam weight_t WMax = {1'b0, {(WEIGHT_BITS-1){1'b1}}};
  localparam weight_t WMin = {1'b1, {(WEIGHT_BITS-1){1'b0}}};

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   init_cnt_q, init_cnt_d;
  logic [HIST_LEN-1:0]   spec_ghr_q, spec_ghr_d;
  weight_t               weights_q [NUM_PERCEPTRONS][HIST_LEN+1];
  weight_t               new_row [HIST_LEN+1];

  logic [IDX_BITS-1:0]   req_idx, fb_idx;
  sum_t                  req_sum, fb_sum, fb_abs;
  logic                  req_fire, fb_fire, req_taken, train;
  logic                  unused_pc_bits;

  // Saturating +/-1 step of a single weight.
  function automatic weight_t sat_step(input weight_t w, input logic inc);
    if (inc) return (w == WMax) ? w : w + weight_t'(1);
    else     return (w == WMin) ? w : w - weight_t'(1);
  endfunction

  assign o_ready   = (state_q == StRun);
  assign req_fire  = o_ready & i_req_valid;
  assign fb_fire   = o_ready & i_fb_valid;
  assign req_idx   = i_req_pc[IDX_BITS+1:2] ^ spec_ghr_q[IDX_BITS-1:0];
  assign fb_idx    = i_fb_pc[IDX_BITS+1:2] ^ i_fb_hist[IDX_BITS-1:0];
  assign req_taken = ~req_sum[SUM_BITS-1];
  assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:IDX_BITS+2], i_req_pc[1:0],
                            i_fb_pc[ADDR_WIDTH-1:IDX_BITS+2], i_fb_pc[1:0]};

  always_comb begin
    req_sum = sum_t'(weights_q[req_idx][0]);
    fb_sum  = sum_t'(weights_q[fb_idx][0]);
    for (int i = 1; i <= int'(HIST_LEN); i++) begin
      if (spec_ghr_q[i-1]) req_sum = req_sum + sum_t'(weights_q[req_idx][i]);
      else                 req_sum = req_sum - sum_t'(weights_q[req_idx][i]);
      if (i_fb_hist[i-1])  fb_sum  = fb_sum + sum_t'(weights_q[fb_idx][i]);
      else                 fb_sum  = fb_sum - sum_t'(weights_q[fb_idx][i]);
    end
  end

  // Train on a wrong-sign or low-confidence sum.
  always_comb begin
    fb_abs = fb_sum[SUM_BITS-1] ? -fb_sum : fb_sum;
    train  = fb_fire & (((~fb_sum[SUM_BITS-1]) != i_fb_taken) | (int'(fb_abs) <= THRESHOLD));
    new_row[0] = sat_step(weights_q[fb_idx][0], i_fb_taken);
    for (int i = 1; i <= int'(HIST_LEN); i++) begin
      new_row[i] = sat_step(weights_q[fb_idx][i], i_fb_taken == i_fb_hist[i-1]);
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_BITS'(NUM_PERCEPTRONS - 1)) state_d = StRun;
      end
      StRun: ;
      default: state_d = StInit;
    endcase
  end

  // Mispredict recovery wins over the shift of a same-cycle request.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (fb_fire && i_fb_mispredict) begin
      spec_ghr_d = {i_fb_hist[HIST_LEN-2:0], i_fb_taken};
    end else if (req_fire) begin
      spec_ghr_d = {spec_ghr_q[HIST_LEN-2:0], req_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      spec_ghr_q   <= '0;
      o_pred_valid <= 1'b0;
      o_pred_taken <= 1'b0;
      o_pred_hist  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      spec_ghr_q   <= spec_ghr_d;
      o_pred_valid <= req_fire;
      if (req_fire) begin
        o_pred_taken <= req_taken;
        o_pred_hist  <= spec_ghr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state_q == StInit) begin
      for (int i = 0; i <= int'(HIST_LEN); i++) weights_q[init_cnt_q][i] <= '0;
    end else if (rst_n && train) begin
      for (int i = 0; i <= int'(HIST_LEN); i++) weights_q[fb_idx][i] <= new_row[i];
    end
  end

endmodule

// File: tb/tb_pipelined_perceptron_predictor.sv
// Self-checking bench: behavioural perceptron model checked every cycle plus directed literals.
module tb_pipelined_perceptron_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready, pred_valid, pred_taken;
  logic [7:0]  pred_hist;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        fb_valid = 1'b0, fb_taken = 1'b0, fb_mispredict = 1'b0;
  logic [31:0] fb_pc = '0;
  logic [7:0]  fb_hist = '0;

  logic        s_ready, s_pred_valid, s_pred_taken;
  logic [7:0]  s_pred_hist;
  logic        s_fb_valid = 1'b0, s_fb_taken = 1'b0;
  logic [7:0]  s_fb_hist = '0;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pipelined_perceptron_predictor #(
    .ADDR_WIDTH(32), .HIST_LEN(8), .NUM_PERCEPTRONS(64), .WEIGHT_BITS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .o_ready(ready),
    .i_req_valid(req_valid), .i_req_pc(req_pc),
    .o_pred_valid(pred_valid), .o_pred_taken(pred_taken), .o_pred_hist(pred_hist),
    .i_fb_valid(fb_valid), .i_fb_pc(fb_pc), .i_fb_hist(fb_hist),
    .i_fb_taken(fb_taken), .i_fb_mispredict(fb_mispredict)
  );

  pipelined_perceptron_predictor #(
    .ADDR_WIDTH(32), .HIST_LEN(8), .NUM_PERCEPTRONS(64), .WEIGHT_BITS(4), .THRESHOLD(200)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .o_ready(s_ready),
    .i_req_valid(1'b0), .i_req_pc(32'h0),
    .o_pred_valid(s_pred_valid), .o_pred_taken(s_pred_taken), .o_pred_hist(s_pred_hist),
    .i_fb_valid(s_fb_valid), .i_fb_pc(32'h400), .i_fb_hist(s_fb_hist),
    .i_fb_taken(s_fb_taken), .i_fb_mispredict(1'b0)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         mw [64][9];
  logic [7:0] m_ghr = '0;
  bit         m_ready = 1'b0, m_pv = 1'b0, m_pt = 1'b0;
  logic [7:0] m_ph = '0;
  int         m_cnt = 0;
  int         m_last_fi = 0;
  int         mi_r, mi_f, ms_r, ms_f, mx;
  bit         mp_t;
  logic [7:0] m_ng;

  function automatic int midx(input logic [31:0] pc, input logic [7:0] h);
    return int'((pc >> 2) ^ {24'h0, h}) & 63;
  endfunction

  function automatic int msum(input int row, input logic [7:0] h);
    int s;
    s = mw[row][0];
    for (int i = 1; i <= 8; i++) s += h[i-1] ? mw[row][i] : -mw[row][i];
    return s;
  endfunction

  function automatic int sat8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_ready = 0; m_pv = 0; m_pt = 0; m_ph = '0; m_ghr = '0;
    end else if (!m_ready) begin
      for (int i = 0; i < 9; i++) mw[m_cnt][i] = 0;
      m_cnt++;
      if (m_cnt == 64) m_ready = 1;
      m_pv = 0;
    end else begin
      mi_r = midx(req_pc, m_ghr);
      ms_r = msum(mi_r, m_ghr);
      mp_t = (ms_r >= 0);
      m_ng = m_ghr;
      if (req_valid) begin
        m_ng = {m_ghr[6:0], mp_t};
        m_pt = mp_t;
        m_ph = m_ghr;
      end
      m_pv = req_valid;
      if (fb_valid) begin
        mi_f = midx(fb_pc, fb_hist);
        ms_f = msum(mi_f, fb_hist);
        m_last_fi = mi_f;
        if (((ms_f >= 0) != fb_taken) || ((ms_f < 0 ? -ms_f : ms_f) <= 29)) begin
          for (int i = 0; i < 9; i++) begin
            mx = (i == 0) ? 1 : (fb_hist[i-1] ? 1 : -1);
            mw[mi_f][i] = sat8(mw[mi_f][i] + (fb_taken ? mx : -mx));
          end
        end
        if (fb_mispredict) m_ng = {fb_hist[6:0], fb_taken};
      end
      m_ghr = m_ng;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", int'(ready), int'(m_ready));
      chk("pred_valid", int'(pred_valid), int'(m_pv));
      if (m_pv) begin
        chk("pred_taken", int'(pred_taken), int'(m_pt));
        chk("pred_hist", int'(pred_hist), int'(m_ph));
      end
      if (m_ready) begin
        chk("spec_ghr", int'(dut.spec_ghr_q), int'(m_ghr));
        for (int i = 0; i < 9; i++) begin
          chk("row_weight", int'(dut.weights_q[m_last_fi][i]), mw[m_last_fi][i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rv, input logic [31:0] rpc, input bit fv,
                     input logic [31:0] fpc, input logic [7:0] fh, input bit ft, input bit fm);
    req_valid = rv; req_pc = rpc;
    fb_valid = fv; fb_pc = fpc; fb_hist = fh; fb_taken = ft; fb_mispredict = fm;
    @(posedge clk); #1;
    req_valid = 1'b0; fb_valid = 1'b0; fb_mispredict = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, 64);
  endtask

  initial begin
    @(posedge clk); #1;
    cmp_en = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(9);
    cyc(1, 32'h400, 1, 32'h400, 8'hAA, 1, 1);      // dropped: not ready
    chk("drop_pred_valid", int'(pred_valid), 0);
    idle(20);
    chk("ready_mid_sweep", int'(ready), 0);
    rst_n = 1'b0;
    idle(2);
    chk("ready_in_reset", int'(ready), 0);
    rst_n = 1'b1;
    wait_ready("sweep_restart_len");
    chk("ghr_after_drop", int'(dut.spec_ghr_q), 0);

    cyc(1, 32'h400, 0, 0, 0, 0, 0);
    chk("zero_pred_valid", int'(pred_valid), 1);
    chk("zero_pred_taken", int'(pred_taken), 1);
    chk("zero_pred_hist", int'(pred_hist), 0);
    idle(1);
    chk("pred_one_cycle", int'(pred_valid), 0);
    cyc(0, 0, 1, 32'h404, 8'h00, 0, 1);
    chk("ghr_restored_zero", int'(dut.spec_ghr_q), 0);

    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, 32'h400, 8'h00, 0, 0);
      chk("model_train_sum", msum(0, 8'h00), -9 * k);
    end
    chk("w0_after_train", int'(dut.weights_q[0][0]), -4);
    cyc(0, 0, 1, 32'h400, 8'h00, 0, 0);
    chk("no_write_w0", int'(dut.weights_q[0][0]), -4);
    chk("no_write_w1", int'(dut.weights_q[0][1]), 4);
    cyc(1, 32'h400, 0, 0, 0, 0, 0);
    chk("trained_pred_taken", int'(pred_taken), 0);

    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    wait_ready("sweep_len_again");
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h400, 0, 0, 0, 0, 0);
      chk("rec_pred_taken", int'(pred_taken), 1);
    end
    chk("ghr_three_taken", int'(dut.spec_ghr_q), 8'h07);
    cyc(1, 32'h400, 1, 32'h400, 8'h05, 1, 1);
    chk("rec_same_cycle_hist", int'(pred_hist), 8'h07);
    chk("ghr_recovered", int'(dut.spec_ghr_q), 8'h0B);
    cyc(1, 32'h400, 0, 0, 0, 0, 0);
    chk("rec_next_hist", int'(pred_hist), 8'h0B);

    cyc(1, 32'h480, 1, 32'h480, 8'h17, 0, 0);     // same row 0x37
    chk("collide_old_weights", int'(pred_taken), 1);
    chk("collide_ghr", int'(dut.spec_ghr_q), 8'h2F);
    cyc(1, 32'h460, 0, 0, 0, 0, 0);                // row 0x37 with hist 0x2F
    chk("collide_new_weights", int'(pred_taken), 0);

    s_fb_valid = 1'b1; s_fb_hist = 8'hFF; s_fb_taken = 1'b1;
    repeat (10) @(posedge clk);
    #1 s_fb_valid = 1'b0;
    for (int i = 0; i < 9; i++) chk("sat_high", int'(dut_sat.weights_q[63][i]), 7);
    s_fb_valid = 1'b1; s_fb_taken = 1'b0;
    repeat (20) @(posedge clk);
    #1 s_fb_valid = 1'b0;
    for (int i = 0; i < 9; i++) chk("sat_low", int'(dut_sat.weights_q[63][i]), -8);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
